secuenciador_biquad: RTL and testbench
======================================

SECUENCIADOR_BIQUAD -- requirements
Module: secuenciador_biquad

Interface
REQ-001 Parameter SEL_W, default 4: width of the coefficient/operand select bus.
REQ-002 Parameter SEL_NULO, default 4'hF: select code whose coefficient is zero, so the accumulator holds its value.
REQ-003 Parameter DETECTA_FLANCO, default 1: 1 = trigger on the rising edge of cambiar; 0 = trigger on cambiar level (one trigger per cycle high).
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 cambiar  input  1  new-sample strobe from the ADC side.
REQ-007 habilitar  input  1  when low, new triggers are ignored.
REQ-008 clr_err  input  1  synchronous clear of sobrecarga.
REQ-009 sel  output  SEL_W  coefficient and input-mux select.
REQ-010 rst_acum  output  1  synchronous accumulator clear.
REQ-011 leer  output  1  write the rounded accumulator into the state memory head (w).
REQ-012 desp  output  1  shift the state memory (f->f1->f2).
REQ-013 leer_y  output  1  load the rounded accumulator into the output register y.
REQ-014 ocupado  output  1  high while a sample is being processed.
REQ-015 listo  output  1  one-cycle pulse when a sample completes.
REQ-016 sobrecarga  output  1  sticky flag for a dropped trigger.

Function
REQ-017 All outputs SHALL be registered Moore outputs decoded from the state register; no input-to-output combinational path.
REQ-018 FSM states, one clock each, in this order: IDLE, CLR1, MAC0, MAC1, MAC2, STW, CLR2, MAC3, MAC4, MAC5, LDY, SHIFT.
REQ-019 Per-state outputs:
- CLR1 and CLR2: rst_acum=1.
- MACn: sel=n, for n=0..5.
- STW: leer=1.
- LDY: leer_y=1.
- SHIFT: desp=1 and listo=1.
- All other outputs 0.
- sel=SEL_NULO in every non-MAC state.
REQ-020 MAC0..MAC2 SHALL compute w = u*c0 + f1*c1 + f2*c2; MAC3..MAC5 SHALL compute y = w*c3 + f1*c4 + f2*c5.
REQ-021 An accepted trigger in IDLE SHALL enter CLR1 on the next edge: trigger-to-leer_y latency is 10 cycles, trigger-to-listo latency is 11 cycles.
REQ-022 Trigger = (DETECTA_FLANCO ? rising edge of registered cambiar : cambiar) AND habilitar.
REQ-023 A trigger while ocupado=1 with pendiente=0 SHALL set internal pendiente; a trigger in the SHIFT cycle counts as pending.
REQ-024 SHIFT SHALL go to CLR1 if pendiente=1 (clearing pendiente), otherwise to IDLE; back-to-back samples therefore take 11 cycles each with no idle gap.
REQ-025 A trigger while pendiente=1 SHALL be dropped and set sobrecarga.
REQ-026 sobrecarga SHALL clear on clr_err; setting has priority over clr_err in the same cycle.
REQ-027 ocupado SHALL be 1 in every state except IDLE.
REQ-028 habilitar falling mid-sample SHALL NOT abort the sample in progress or an already-pending sample.

Reset
REQ-029 rst low SHALL asynchronously force IDLE, pendiente=0, sobrecarga=0, sel=SEL_NULO and all 1-bit outputs 0, including mid-sample.
REQ-030 The first trigger is accepted no earlier than the second rising edge after rst deasserts; the edge detector register resets to 1, so cambiar held high through reset is not a trigger.

Verification
REQ-031 Single pulse on cambiar in IDLE -> output sequence exactly rst_acum, sel 0,1,2, leer, rst_acum, sel 3,4,5, leer_y, desp+listo; ocupado high for 11 cycles.
REQ-032 Stimulus: coefficients c0=1.0, c3=1.0, others 0; u=0x000100; state memory zero -> y=0x000100 after listo.
REQ-033 Second trigger during MAC4 -> CLR1 immediately follows SHIFT, with no IDLE cycle.
REQ-034 Triggers in MAC1, MAC3 and MAC5 -> one pending sample runs, sobrecarga=1; clr_err then clears it.
REQ-035 rst asserted during MAC4 -> outputs go to reset values in the same cycle; the next trigger runs a full, correct sequence.
REQ-036 With DETECTA_FLANCO=1, cambiar held high for 20 cycles -> exactly one sample is processed; habilitar=0 -> no sample.

Source files
------------

// File: rtl/secuenciador_biquad.sv
// Control sequencer for a time-multiplexed biquad section.
// Drives one shared MAC through two three-term sums per sample:
//   w = u*c0 + f1*c1 + f2*c2   (stored into the state memory head)
//   y = w*c3 + f1*c4 + f2*c5   (loaded into the output register)
// then shifts the state memory. One extra trigger can queue behind the
// running sample; any further trigger is dropped and flagged.
module secuenciador_biquad #(
  parameter int unsigned      SEL_W          = 4,
  parameter logic [SEL_W-1:0] SEL_NULO       = 4'hF,
  parameter bit               DETECTA_FLANCO = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cambiar,
  input  logic             habilitar,
  input  logic             clr_err,
  output logic [SEL_W-1:0] sel,
  output logic             rst_acum,
  output logic             leer,
  output logic             desp,
  output logic             leer_y,
  output logic             ocupado,
  output logic             listo,
  output logic             sobrecarga
);

  typedef enum logic [3:0] {
    StIdle,
    StClr1,
    StMac0,
    StMac1,
    StMac2,
    StStw,
    StClr2,
    StMac3,
    StMac4,
    StMac5,
    StLdy,
    StShift
  } estado_e;

  estado_e          estado_q, estado_d;
  logic             cambiar_q;
  logic             arranque_q;
  logic             pendiente_q, pendiente_d;
  logic             sobre_set;
  logic             flanco;
  logic             disparo;

  logic [SEL_W-1:0] sel_d;
  logic             rst_acum_d, leer_d, desp_d, leer_y_d, ocupado_d, listo_d;

  // Trigger qualification; arranque_q blocks triggers on the first edge after reset.
  always_comb begin
    flanco  = DETECTA_FLANCO ? (cambiar & ~cambiar_q) : cambiar;
    disparo = flanco & habilitar & arranque_q;
  end

  // Next state, pending-sample bookkeeping and overload detection.
  always_comb begin
    estado_d    = estado_q;
    pendiente_d = pendiente_q;
    sobre_set   = 1'b0;

    unique case (estado_q)
      StIdle:  if (disparo) estado_d = StClr1;
      StClr1:  estado_d = StMac0;
      StMac0:  estado_d = StMac1;
      StMac1:  estado_d = StMac2;
      StMac2:  estado_d = StStw;
      StStw:   estado_d = StClr2;
      StClr2:  estado_d = StMac3;
      StMac3:  estado_d = StMac4;
      StMac4:  estado_d = StMac5;
      StMac5:  estado_d = StLdy;
      StLdy:   estado_d = StShift;
      // A trigger arriving in SHIFT is treated as already pending and started at once.
      StShift: estado_d = (pendiente_q || disparo) ? StClr1 : StIdle;
      default: estado_d = StIdle;
    endcase

    if (estado_q == StShift) begin
      pendiente_d = 1'b0;
      sobre_set   = disparo & pendiente_q;
    end else if (estado_q != StIdle && disparo) begin
      if (pendiente_q) begin
        sobre_set = 1'b1;
      end else begin
        pendiente_d = 1'b1;
      end
    end
  end

  // Moore output decode from the next state so registered outputs align with the state.
  always_comb begin
    sel_d      = SEL_NULO;
    rst_acum_d = 1'b0;
    leer_d     = 1'b0;
    desp_d     = 1'b0;
    leer_y_d   = 1'b0;
    listo_d    = 1'b0;
    ocupado_d  = (estado_d != StIdle);

    unique case (estado_d)
      StClr1, StClr2: rst_acum_d = 1'b1;
      StMac0:         sel_d = SEL_W'(0);
      StMac1:         sel_d = SEL_W'(1);
      StMac2:         sel_d = SEL_W'(2);
      StMac3:         sel_d = SEL_W'(3);
      StMac4:         sel_d = SEL_W'(4);
      StMac5:         sel_d = SEL_W'(5);
      StStw:          leer_d = 1'b1;
      StLdy:          leer_y_d = 1'b1;
      StShift: begin
        desp_d  = 1'b1;
        listo_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State, flags and registered outputs; edge detector resets high so a held strobe is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q    <= StIdle;
      cambiar_q   <= 1'b1;
      arranque_q  <= 1'b0;
      pendiente_q <= 1'b0;
      sobrecarga  <= 1'b0;
      sel         <= SEL_NULO;
      rst_acum    <= 1'b0;
      leer        <= 1'b0;
      desp        <= 1'b0;
      leer_y      <= 1'b0;
      ocupado     <= 1'b0;
      listo       <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      cambiar_q   <= cambiar;
      arranque_q  <= 1'b1;
      pendiente_q <= pendiente_d;
      if (sobre_set) begin
        sobrecarga <= 1'b1;
      end else if (clr_err) begin
        sobrecarga <= 1'b0;
      end
      sel      <= sel_d;
      rst_acum <= rst_acum_d;
      leer     <= leer_d;
      desp     <= desp_d;
      leer_y   <= leer_y_d;
      ocupado  <= ocupado_d;
      listo    <= listo_d;
    end
  end

endmodule

// File: tb/tb_secuenciador_biquad.sv
// Bench for secuenciador_biquad: a behavioural MAC/state-memory plant follows
// the sequencer's controls, and a formula-level biquad model predicts y.
module tb_secuenciador_biquad;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cambiar = 1'b0;
  logic       habilitar = 1'b1;
  logic       clr_err = 1'b0;
  logic [3:0] sel;
  logic       rst_acum, leer, desp, leer_y, ocupado, listo, sobrecarga;

  int checks = 0;
  int errors = 0;
  int listo_cnt = 0;

  // Plant: Q8 coefficients, shared accumulator, state memory w/f1/f2, output y.
  longint coef [6];
  longint u = 0;
  longint acc, w, f1, f2, y;
  // Model state memory.
  longint m_f1 = 0, m_f2 = 0;

  logic [9:0] dut_vec;
  assign dut_vec = {sel, rst_acum, leer, desp, leer_y, ocupado, listo};

  secuenciador_biquad dut (
    .clk        (clk),
    .rst        (rst),
    .cambiar    (cambiar),
    .habilitar  (habilitar),
    .clr_err    (clr_err),
    .sel        (sel),
    .rst_acum   (rst_acum),
    .leer       (leer),
    .desp       (desp),
    .leer_y     (leer_y),
    .ocupado    (ocupado),
    .listo      (listo),
    .sobrecarga (sobrecarga)
  );

  always #5 clk = ~clk;

  function automatic longint operando(input logic [3:0] s);
    case (s)
      4'd0:       return u;
      4'd1, 4'd4: return f1;
      4'd2, 4'd5: return f2;
      4'd3:       return w;
      default:    return 0;
    endcase
  endfunction

  function automatic longint coef_de(input logic [3:0] s);
    if (s < 4'd6) return coef[s];
    return 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= 0; w <= 0; f1 <= 0; f2 <= 0; y <= 0;
    end else begin
      if (rst_acum) acc <= 0;
      else acc <= acc + ((operando(sel) * coef_de(sel)) >>> 8);
      if (leer) w <= acc;
      if (leer_y) y <= acc;
      if (desp) begin
        f1 <= w;
        f2 <= f1;
      end
    end
  end

  always @(negedge clk) if (rst && listo) listo_cnt <= listo_cnt + 1;

  // Expected control vector k cycles after the trigger edge (k = -1 means idle).
  function automatic logic [9:0] exp_vec(input int k);
    logic [3:0] s;
    logic ra, le, de, ly, oc, li;
    s = 4'hF; ra = 0; le = 0; de = 0; ly = 0; li = 0;
    oc = (k >= 0);
    case (k)
      0, 5:    ra = 1'b1;
      1, 2, 3: s = 4'(k - 1);
      4:       le = 1'b1;
      6, 7, 8: s = 4'(k - 3);
      9:       ly = 1'b1;
      10: begin de = 1'b1; li = 1'b1; end
      default: ;
    endcase
    return {s, ra, le, de, ly, oc, li};
  endfunction

  // Biquad at formula level; returns y and advances the model memory.
  function automatic longint modelo(input longint uu);
    longint mw, my;
    mw = ((uu * coef[0]) >>> 8) + ((m_f1 * coef[1]) >>> 8) + ((m_f2 * coef[2]) >>> 8);
    my = ((mw * coef[3]) >>> 8) + ((m_f1 * coef[4]) >>> 8) + ((m_f2 * coef[5]) >>> 8);
    m_f2 = m_f1;
    m_f1 = mw;
    return my;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    cambiar = 1'b1;
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (dut_vec !== exp_vec(-1) || sobrecarga !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: got %h/%b expected %h/0", dut_vec, sobrecarga, exp_vec(-1));
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (ocupado !== 1'b0) begin
        errors++;
        $display("FAIL held_through_reset cyc %0d: ocupado got %b expected 0", i, ocupado);
      end
    end
    cambiar = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_single();
    longint ey;
    coef = '{256, 0, 0, 256, 0, 0};
    u = 64'h100;
    ey = modelo(u);
    cambiar = 1'b1;
    tick();
    cambiar = 1'b0;
    for (int k = 0; k <= 11; k++) begin
      if (k > 0) tick();
      checks++;
      if (dut_vec !== exp_vec(k > 10 ? -1 : k)) begin
        errors++;
        $display("FAIL single_seq k=%0d: got %h expected %h", k, dut_vec, exp_vec(k > 10 ? -1 : k));
      end
    end
    checks++;
    if (y !== 64'h100) begin
      errors++;
      $display("FAIL single_y: got %h expected 100", y);
    end
    checks++;
    if (y !== ey) begin
      errors++;
      $display("FAIL single_y_model: got %h expected %h", y, ey);
    end
  endtask

  task automatic test_back_to_back();
    int ex;
    cambiar = 1'b1;
    tick();
    for (int k = 0; k <= 22; k++) begin
      if (k > 0) tick();
      cambiar = (k == 7);
      ex = (k <= 10) ? k : ((k <= 21) ? k - 11 : -1);
      checks++;
      if (dut_vec !== exp_vec(ex)) begin
        errors++;
        $display("FAIL b2b_seq k=%0d: got %h expected %h", k, dut_vec, exp_vec(ex));
      end
    end
    cambiar = 1'b0;
    checks++;
    if (sobrecarga !== 1'b0) begin
      errors++;
      $display("FAIL b2b_sobrecarga: got %b expected 0", sobrecarga);
    end
  endtask

  task automatic test_overload();
    int n0;
    n0 = listo_cnt;
    cambiar = 1'b1;
    tick();
    for (int k = 0; k <= 30; k++) begin
      if (k > 0) tick();
      if (k == 5) begin
        checks++;
        if (sobrecarga !== 1'b0) begin
          errors++;
          $display("FAIL ovl_early: got %b expected 0", sobrecarga);
        end
      end
      if (k == 7) begin
        checks++;
        if (sobrecarga !== 1'b1) begin
          errors++;
          $display("FAIL ovl_set: got %b expected 1", sobrecarga);
        end
      end
      if (k == 11) begin
        checks++;
        if (dut_vec !== exp_vec(0)) begin
          errors++;
          $display("FAIL ovl_restart: got %h expected %h", dut_vec, exp_vec(0));
        end
      end
      cambiar = (k == 2 || k == 6 || k == 8);
    end
    checks++;
    if (listo_cnt - n0 !== 2) begin
      errors++;
      $display("FAIL ovl_samples: got %0d expected 2", listo_cnt - n0);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tick();
    checks++;
    if (sobrecarga !== 1'b0) begin
      errors++;
      $display("FAIL ovl_clear: got %b expected 0", sobrecarga);
    end
    // Set wins over a simultaneous clear.
    cambiar = 1'b1;
    tick();
    for (int k = 0; k <= 30; k++) begin
      if (k > 0) tick();
      if (k == 6) begin
        checks++;
        if (sobrecarga !== 1'b1) begin
          errors++;
          $display("FAIL ovl_priority: got %b expected 1", sobrecarga);
        end
      end
      cambiar = (k == 2 || k == 5);
      clr_err = (k == 5);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tick();
    checks++;
    if (sobrecarga !== 1'b0) begin
      errors++;
      $display("FAIL ovl_clear2: got %b expected 0", sobrecarga);
    end
  endtask

  task automatic test_held_high();
    int n0;
    bit visto;
    n0 = listo_cnt;
    cambiar = 1'b1;
    repeat (20) tick();
    cambiar = 1'b0;
    repeat (12) tick();
    checks++;
    if (listo_cnt - n0 !== 1) begin
      errors++;
      $display("FAIL held_high: got %0d samples expected 1", listo_cnt - n0);
    end
    // Disabled: no sample at all.
    n0 = listo_cnt;
    visto = 0;
    habilitar = 1'b0;
    cambiar = 1'b1;
    tick();
    cambiar = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (ocupado) visto = 1;
      tick();
    end
    checks++;
    if (visto || (listo_cnt - n0) != 0) begin
      errors++;
      $display("FAIL disabled: got busy=%0b samples=%0d expected 0/0", visto, listo_cnt - n0);
    end
    // Enable falling after a sample and a pending sample are accepted.
    habilitar = 1'b1;
    n0 = listo_cnt;
    cambiar = 1'b1;
    tick();
    for (int k = 0; k <= 25; k++) begin
      if (k > 0) tick();
      cambiar = (k == 3);
      if (k == 4) habilitar = 1'b0;
    end
    checks++;
    if (listo_cnt - n0 !== 2) begin
      errors++;
      $display("FAIL enable_fall: got %0d samples expected 2", listo_cnt - n0);
    end
    habilitar = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    int n0;
    longint ey;
    cambiar = 1'b1;
    tick();
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) tick();
      cambiar = (k == 2 || k == 4);
    end
    checks++;
    if (sobrecarga !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: sobrecarga got %b expected 1", sobrecarga);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (dut_vec !== exp_vec(-1) || sobrecarga !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got %h/%b expected %h/0", dut_vec, sobrecarga, exp_vec(-1));
    end
    tick();
    rst = 1'b1;
    m_f1 = 0;
    m_f2 = 0;
    repeat (2) tick();
    n0 = listo_cnt;
    u = 64'h345;
    ey = modelo(u);
    cambiar = 1'b1;
    tick();
    cambiar = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) tick();
      checks++;
      if (dut_vec !== exp_vec(k > 10 ? -1 : k)) begin
        errors++;
        $display("FAIL mid_seq k=%0d: got %h expected %h", k, dut_vec, exp_vec(k > 10 ? -1 : k));
      end
    end
    checks++;
    if (listo_cnt - n0 !== 1 || y !== ey) begin
      errors++;
      $display("FAIL mid_after: got %0d samples y=%h expected 1 y=%h", listo_cnt - n0, y, ey);
    end
  endtask

  task automatic test_random();
    longint ey;
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    m_f1 = 0;
    m_f2 = 0;
    repeat (2) tick();
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 6; i++) coef[i] = longint'($urandom_range(200, 0));
      u = longint'($urandom_range(4095, 0));
      ey = modelo(u);
      cambiar = 1'b1;
      tick();
      cambiar = 1'b0;
      repeat (11) tick();
      checks++;
      if (y !== ey || f1 !== m_f1) begin
        errors++;
        $display("FAIL random_y n=%0d: got y=%0d f1=%0d expected y=%0d f1=%0d",
                 n, y, f1, ey, m_f1);
      end
      repeat ($urandom_range(3, 0)) tick();
    end
  endtask

  initial begin
    coef = '{0, 0, 0, 0, 0, 0};
    test_reset();
    test_single();
    test_back_to_back();
    test_overload();
    test_held_high();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
